// File: rtl/alu_exec_stage_if.sv
// Request/write-back bundle between the control unit, register file and alu_exec_stage.
// master = control side (drives request), slave = the execute stage.
interface alu_exec_stage_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ADDRW = 4
);
   logic             Start;
   logic [3:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [ADDRW-1:0] Dst;
   logic [WIDTH-1:0] C;
   logic [ADDRW-1:0] Caddr;
   logic             Load;
   logic             Busy;
   logic             Done;
   logic             Err;
   logic [3:0]       Flags;

   modport master (
      output Start, Op, A, B, Dst,
      input  C, Caddr, Load, Busy, Done, Err, Flags
   );

   modport slave (
      input  Start, Op, A, B, Dst,
      output C, Caddr, Load, Busy, Done, Err, Flags
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage feeding the register file write port (C, Caddr, Load).
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for opcode 9.
module alu_exec_stage #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ADDRW     = 4,
   parameter int unsigned MUL_STEPS = 16
) (
   input  logic            Clk,
   input  logic            Clear,
   alu_exec_stage_if.slave bus
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOT  = 4'd5,
      OP_SHL  = 4'd6,
      OP_SHR  = 4'd7,
      OP_PASS = 4'd8,
      OP_MUL  = 4'd9
   } op_e;

`ifdef ALU_MUL_EN
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_WB, S_ERR} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB, S_ERR} state_e;
`endif

   state_e           r_state;
   state_e           w_state_nxt;
   op_e              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [ADDRW-1:0] r_dst;
   logic [WIDTH-1:0] r_c;
   logic [ADDRW-1:0] r_caddr;
   logic [3:0]       r_flags;
   logic             w_accept;
   logic             w_op_legal;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_cy;
   logic             w_v;

`ifdef ALU_MUL_EN
   localparam int unsigned   CNTW      = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   localparam logic [CNTW-1:0] LAST_STEP = CNTW'(MUL_STEPS - 1);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0]   r_mplr;
   logic [CNTW-1:0]    r_cnt;
   logic               w_mul_last;

   assign w_op_legal = (bus.Op <= 4'd9);
`else
   assign w_op_legal = (bus.Op <= 4'd8);
`endif

   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.Start) begin
               w_accept = 1'b1;
               if (!w_op_legal)           w_state_nxt = S_ERR;
`ifdef ALU_MUL_EN
               else if (bus.Op == OP_MUL) w_state_nxt = S_MUL;
`endif
               else                       w_state_nxt = S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_WB;
`ifdef ALU_MUL_EN
         S_MUL:   if (r_cnt == LAST_STEP) w_state_nxt = S_WB;
`endif
         S_WB:    w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.Load  = (r_state == S_WB);
   assign bus.Done  = (r_state == S_WB);
   assign bus.Busy  = (r_state != S_IDLE);
   assign bus.Err   = (r_state == S_ERR);
   assign bus.C     = r_c;
   assign bus.Caddr = r_caddr;
   assign bus.Flags = r_flags;

   // Operands and Dst are only sampled when a request is accepted in IDLE.
   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         r_op  <= OP_ADD;
         r_a   <= '0;
         r_b   <= '0;
         r_dst <= '0;
      end else if (w_accept) begin
         r_op  <= op_e'(bus.Op);
         r_a   <= bus.A;
         r_b   <= bus.B;
         r_dst <= bus.Dst;
      end
   end

   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, r_b};
      w_diff = {1'b0, r_a} - {1'b0, r_b};
      w_res  = '0;
      w_cy   = 1'b0;
      w_v    = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_cy  = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_cy  = ~w_diff[WIDTH];
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_XOR:  w_res = r_a ^ r_b;
         OP_NOT:  w_res = ~r_a;
         OP_SHL:  w_res = r_a << r_b[3:0];
         OP_SHR:  w_res = r_a >> r_b[3:0];
         OP_PASS: w_res = r_b;
         default: w_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   // Multiplier bits consumed LSB first; the multiplicand walks left across the wide accumulator.
   assign w_acc_nxt  = r_acc + (r_mplr[0] ? r_mcand : '0);
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == LAST_STEP);

   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_acc   <= '0;
         r_mcand <= {{WIDTH{1'b0}}, bus.A};
         r_mplr  <= bus.B;
         r_cnt   <= '0;
      end else if (r_state == S_MUL) begin
         r_acc   <= w_acc_nxt;
         r_mcand <= r_mcand << 1;
         r_mplr  <= r_mplr >> 1;
         r_cnt   <= r_cnt + 1'b1;
      end
   end
`endif

   // Results land on the edge entering WB and then hold until the next WB.
   always_ff @(posedge Clk or negedge Clear) begin
      if (!Clear) begin
         r_c     <= '0;
         r_caddr <= '0;
         r_flags <= '0;
      end else if (r_state == S_EXEC) begin
         r_c     <= w_res;
         r_caddr <= r_dst;
         r_flags <= {w_res[WIDTH-1], (w_res == '0), w_cy, w_v};
      end
`ifdef ALU_MUL_EN
      else if (w_mul_last) begin
         r_c     <= w_acc_nxt[WIDTH-1:0];
         r_caddr <= r_dst;
         r_flags <= {w_acc_nxt[WIDTH-1], (w_acc_nxt[WIDTH-1:0] == '0),
                     (w_acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
      end
`endif
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: timeline reference model plus per-cycle compare.
`timescale 1ns/1ps
module tb_alu_exec_stage;
   localparam int unsigned W     = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned STEPS = 16;

   logic Clk   = 1'b0;
   logic Clear = 1'b0;

   alu_exec_stage_if #(.WIDTH(W), .ADDRW(AW)) bus ();

   alu_exec_stage #(.WIDTH(W), .ADDRW(AW), .MUL_STEPS(STEPS)) dut (
      .Clk   (Clk),
      .Clear (Clear),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic        legal;
      logic [15:0] c;
      logic [3:0]  fl;
   } res_t;

   // Result and {N,Z,Cy,V} straight from integer arithmetic.
   function automatic res_t model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      res_t        r;
      int unsigned ua, ub, ur;
      int          sa, sb, sr;
      logic        cy, v;
      ua = 32'(a);
      ub = 32'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ur = 0;
      sr = 0;
      cy = 1'b0;
      v  = 1'b0;
      r.legal = 1'b1;
      case (op)
         4'd0: begin
            ur = ua + ub; sr = sa + sb;
            cy = (ur > 32'hFFFF);
            v  = (sr > 32767) || (sr < -32768);
         end
         4'd1: begin
            ur = ua - ub; sr = sa - sb;
            cy = (ua >= ub);
            v  = (sr > 32767) || (sr < -32768);
         end
         4'd2: ur = ua & ub;
         4'd3: ur = ua | ub;
         4'd4: ur = ua ^ ub;
         4'd5: ur = ~ua;
         4'd6: ur = ua << (ub % 16);
         4'd7: ur = ua >> (ub % 16);
         4'd8: ur = ub;
`ifdef ALU_MUL_EN
         4'd9: begin
            ur = ua * ub;
            cy = ((ur >> 16) != 0);
         end
`endif
         default: r.legal = 1'b0;
      endcase
      r.c  = ur[15:0];
      r.fl = {r.c[15], (r.c == 16'h0000), cy, v};
      return r;
   endfunction

   // Expected outputs per cycle, indexed by the rising edge that starts the cycle.
   int          n         = 0;
   int          busy_last = -1;
   int          load_iv   = -1;
   int          err_iv    = -1;
   res_t        pend;
   logic [3:0]  pend_dst  = '0;
   logic        e_busy    = 1'b0;
   logic        e_load    = 1'b0;
   logic        e_err     = 1'b0;
   logic [15:0] e_c       = '0;
   logic [3:0]  e_caddr   = '0;
   logic [3:0]  e_fl      = '0;

   initial begin : model
      res_t r;
      pend = '0;
      forever begin
         @(posedge Clk or negedge Clear);
         if (!Clear) begin
            n = 0; busy_last = -1; load_iv = -1; err_iv = -1;
            e_busy = 1'b0; e_load = 1'b0; e_err = 1'b0;
            e_c = '0; e_caddr = '0; e_fl = '0;
         end else begin
            n++;
            if (bus.Start && busy_last < n - 1) begin
               r = model_op(bus.Op, bus.A, bus.B);
               if (!r.legal) begin
                  err_iv    = n;
                  busy_last = n;
               end else begin
                  load_iv   = n + ((bus.Op == 4'd9) ? int'(STEPS) : 1);
                  busy_last = load_iv;
                  pend      = r;
                  pend_dst  = bus.Dst;
               end
            end
            e_busy = (n <= busy_last);
            e_err  = (n == err_iv);
            e_load = (n == load_iv);
            if (e_load) begin
               e_c     = pend.c;
               e_caddr = pend_dst;
               e_fl    = pend.fl;
            end
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d got %0h want %0h", nm, n, act, exp);
      end
   endtask

   initial begin : compare
      res_t p;
      p = model_op(4'd0, 16'h7FFF, 16'h0001);
      chk("pin_add_c", 32'(p.c), 32'h8000);
      chk("pin_add_fl", 32'(p.fl), 32'b1001);
      p = model_op(4'd1, 16'h0005, 16'h0005);
      chk("pin_sub_c", 32'(p.c), 32'h0000);
      chk("pin_sub_fl", 32'(p.fl), 32'b0110);
      p = model_op(4'hC, 16'h1234, 16'h5678);
      chk("pin_illegal", 32'(p.legal), 32'h0);
`ifdef ALU_MUL_EN
      p = model_op(4'd9, 16'h0012, 16'h0034);
      chk("pin_mul1_c", 32'(p.c), 32'h03A8);
      chk("pin_mul1_fl", 32'(p.fl), 32'b0000);
      p = model_op(4'd9, 16'hFFFF, 16'h0002);
      chk("pin_mul2_c", 32'(p.c), 32'hFFFE);
      chk("pin_mul2_fl", 32'(p.fl), 32'b1010);
`else
      p = model_op(4'd9, 16'h0012, 16'h0034);
      chk("pin_mul_illegal", 32'(p.legal), 32'h0);
`endif
      forever begin
         @(negedge Clk or negedge Clear);
         if (!Clear) #1;
         chk("Busy",  32'(bus.Busy),  32'(e_busy));
         chk("Load",  32'(bus.Load),  32'(e_load));
         chk("Done",  32'(bus.Done),  32'(e_load));
         chk("Err",   32'(bus.Err),   32'(e_err));
         chk("C",     32'(bus.C),     32'(e_c));
         chk("Caddr", 32'(bus.Caddr), 32'(e_caddr));
         chk("Flags", 32'(bus.Flags), 32'(e_fl));
      end
   end

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drive(input logic st, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] d);
      @(negedge Clk);
      #1;
      bus.Start = st;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.Dst   = d;
   endtask

   task automatic idle(input int k);
      repeat (k) drive(1'b0, 4'd0, 16'h0000, 16'h0000, 4'h0);
   endtask

   initial begin : stim
      bus.Start = 1'b0;
      bus.Op    = '0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Dst   = '0;
      repeat (3) @(negedge Clk);
      #1 Clear = 1'b1;
      idle(2);

      drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'h3); idle(5);
      drive(1'b1, 4'd1, 16'h0005, 16'h0005, 4'hA); idle(5);
      drive(1'b1, 4'd9, 16'h0012, 16'h0034, 4'h1); idle(20);
      drive(1'b1, 4'd9, 16'hFFFF, 16'h0002, 4'h2); idle(20);

      drive(1'b1, 4'd9, 16'h1234, 16'h0101, 4'h5);
      repeat (18) drive(1'b1, 4'($urandom_range(0, 15)), rnd16(), rnd16(), 4'($urandom));
      idle(22);

      drive(1'b1, 4'd9, 16'hABCD, 16'h00FF, 4'h7);
      @(posedge Clk);
      repeat (7) @(posedge Clk);
      #2;
      Clear     = 1'b0;
      bus.Start = 1'b0;
      repeat (2) @(negedge Clk);
      #1 Clear = 1'b1;
      idle(3);
      drive(1'b1, 4'd0, 16'h1111, 16'h2222, 4'h9); idle(5);

      drive(1'b1, 4'hC, 16'h5555, 16'h3333, 4'h4); idle(4);
      drive(1'b1, 4'd9, 16'h0003, 16'h0004, 4'h6); idle(20);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15)),
               rnd16(), rnd16(), 4'($urandom));
      end
      idle(25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
